keypad_debounce_rpt: RTL and testbench

//   Parametrised keypad debouncer. It sits between the keypad scanner and the calculator input logic.
//   - Qualifies a single-hot key vector over a press interval and a release interval.
//   - Commits the key either on qualified press or on qualified release.
//   - Optional auto-repeat while a key is held.
//   - Delivers codes over a valid/ready handshake with a one-entry holding register and drop reporting.

---
 rtl/keypad_debounce_rpt.sv | 191 +++++++++++++++++++
 tb/tb_keypad_debounce_rpt.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_rpt.sv
// Keypad debouncer: qualifies a one-hot key press/release, commits the key
// on press or release (optionally with auto-repeat while held), and hands the
// code to the consumer through a one-entry valid/ready holding register.
module keypad_debounce_rpt #(
    parameter int unsigned WIDTH             = 16,
    parameter int unsigned PRESS_CYCLES      = 1000,
    parameter int unsigned RELEASE_CYCLES    = 1000,
    parameter bit          COMMIT_ON_RELEASE = 1'b1,
    parameter bit          REPEAT_EN         = 1'b0,
    parameter int unsigned REPEAT_DELAY      = 50000,
    parameter int unsigned REPEAT_PERIOD     = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] keys_in,
    input  logic             key_ready,
    output logic [WIDTH-1:0] key_data,
    output logic             key_valid,
    output logic             key_drop,
    output logic             key_held,
    output logic [1:0]       state_dbg
);

    localparam int unsigned QualMax = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES
                                                                       : RELEASE_CYCLES;
    localparam int unsigned RptMax  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned CntW    = $clog2(QualMax + 1);
    localparam int unsigned RptW    = $clog2(RptMax + 1);

    localparam logic [CntW-1:0] PressLast  = CntW'(PRESS_CYCLES - 1);
    localparam logic [CntW-1:0] RelLast    = CntW'(RELEASE_CYCLES - 1);
    localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

    // Auto-repeat only makes sense when keys commit on press.
    localparam bit RepeatOn = REPEAT_EN && !COMMIT_ON_RELEASE;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StPressQual = 2'b01,
        StHeld      = 2'b10,
        StRelQual   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RptW-1:0]  rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
    logic             commit_q, commit_d;
    logic [WIDTH-1:0] commit_data_q, commit_data_d;
    logic [WIDTH-1:0] key_data_q, key_data_d;
    logic             key_valid_q, key_valid_d;
    logic             key_drop_q, key_drop_d;
    logic             one_hot;

    assign one_hot = (keys_in != '0) && ((keys_in & (keys_in - WIDTH'(1))) == '0);

    // Debounce FSM next-state, qualification counters and commit generation.
    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        cnt_d         = cnt_q;
        rpt_d         = rpt_q;
        rpt_first_d   = rpt_first_q;
        commit_d      = 1'b0;
        commit_data_d = commit_data_q;

        unique case (state_q)
            StIdle: begin
                if (one_hot) begin
                    cap_d   = keys_in;
                    cnt_d   = '0;
                    state_d = StPressQual;
                end
            end
            StPressQual: begin
                if (keys_in != cap_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == PressLast) begin
                    state_d     = StHeld;
                    cnt_d       = '0;
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
                    commit_d    = !COMMIT_ON_RELEASE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (keys_in == cap_q) begin
                    if (RepeatOn) begin
                        // First repeat waits the long delay, later ones the period.
                        if (rpt_q == (rpt_first_q ? DelayLast : PeriodLast)) begin
                            commit_d    = 1'b1;
                            rpt_d       = '0;
                            rpt_first_d = 1'b0;
                        end else begin
                            rpt_d = rpt_q + RptW'(1);
                        end
                    end
                end else begin
                    state_d = StRelQual;
                    cnt_d   = '0;
                    rpt_d   = '0;
                end
            end
            StRelQual: begin
                if (keys_in == '0) begin
                    if (cnt_q == RelLast) begin
                        state_d  = StIdle;
                        cnt_d    = '0;
                        commit_d = COMMIT_ON_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (keys_in == cap_q) begin
                    // Release bounce: back to held, repeat timing starts over.
                    state_d     = StHeld;
                    cnt_d       = '0;
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                rpt_d   = '0;
            end
        endcase

        if (commit_d) begin
            commit_data_d = cap_q;
        end
    end

    // One-entry holding register: accept a commit unless an unaccepted code blocks it.
    always_comb begin
        key_data_d  = key_data_q;
        key_valid_d = key_valid_q;
        key_drop_d  = 1'b0;
        if (commit_q) begin
            if (!key_valid_q || key_ready) begin
                key_data_d  = commit_data_q;
                key_valid_d = 1'b1;
            end else begin
                key_drop_d = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cap_q         <= '0;
            cnt_q         <= '0;
            rpt_q         <= '0;
            rpt_first_q   <= 1'b0;
            commit_q      <= 1'b0;
            commit_data_q <= '0;
            key_data_q    <= '0;
            key_valid_q   <= 1'b0;
            key_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            cnt_q         <= cnt_d;
            rpt_q         <= rpt_d;
            rpt_first_q   <= rpt_first_d;
            commit_q      <= commit_d;
            commit_data_q <= commit_data_d;
            key_data_q    <= key_data_d;
            key_valid_q   <= key_valid_d;
            key_drop_q    <= key_drop_d;
        end
    end

    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign key_drop  = key_drop_q;
    assign key_held  = (state_q == StHeld) || (state_q == StRelQual);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_debounce_rpt.sv
// Bench for keypad_debounce_rpt: three instances share the key/ready inputs
// (A: release commit, B: press commit with repeat, C: release commit, PRESS=8).
// Expected commits are derived per key segment from the timing rules.
module tb_keypad_debounce_rpt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys_in = '0;
    logic        key_ready = 1'b0;

    logic [15:0] data_a, data_b, data_c;
    logic        valid_a, valid_b, valid_c;
    logic        drop_a, drop_b, drop_c;
    logic        held_a, held_b, held_c;
    logic [1:0]  st_a, st_b, st_c;

    always #5 clk = ~clk;

    keypad_debounce_rpt #(
        .WIDTH(16), .PRESS_CYCLES(4), .RELEASE_CYCLES(4), .COMMIT_ON_RELEASE(1'b1),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_a (
        .clk(clk), .rst(rst), .keys_in(keys_in), .key_ready(key_ready),
        .key_data(data_a), .key_valid(valid_a), .key_drop(drop_a),
        .key_held(held_a), .state_dbg(st_a)
    );

    keypad_debounce_rpt #(
        .WIDTH(16), .PRESS_CYCLES(4), .RELEASE_CYCLES(4), .COMMIT_ON_RELEASE(1'b0),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_b (
        .clk(clk), .rst(rst), .keys_in(keys_in), .key_ready(key_ready),
        .key_data(data_b), .key_valid(valid_b), .key_drop(drop_b),
        .key_held(held_b), .state_dbg(st_b)
    );

    keypad_debounce_rpt #(
        .WIDTH(16), .PRESS_CYCLES(8), .RELEASE_CYCLES(4), .COMMIT_ON_RELEASE(1'b1),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_c (
        .clk(clk), .rst(rst), .keys_in(keys_in), .key_ready(key_ready),
        .key_data(data_c), .key_valid(valid_c), .key_drop(drop_c),
        .key_held(held_c), .state_dbg(st_c)
    );

    // Per-instance configuration of the reference model.
    int unsigned press_c [3] = '{4, 4, 8};
    bit          cor_c   [3] = '{1'b1, 1'b0, 1'b1};
    bit          rep_c   [3] = '{1'b0, 1'b1, 1'b0};
    localparam int unsigned RelCycles = 4;
    localparam int unsigned RptDelay  = 20;
    localparam int unsigned RptPeriod = 5;

    typedef struct {
        int          inst;
        int unsigned edge_no;
        logic [15:0] key;
    } ev_t;

    ev_t         evq[$];
    logic [15:0] m_data  [3];
    bit          m_valid [3];
    bit          m_drop  [3];

    int unsigned edge_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_idle_st = 1'b0;
    bit          chk_c_not_held = 1'b0;
    int          b_valid_cycles = 0;
    int          a_drop_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic logic [15:0] obs_data(int i);
        return (i == 0) ? data_a : (i == 1) ? data_b : data_c;
    endfunction
    function automatic logic obs_valid(int i);
        return (i == 0) ? valid_a : (i == 1) ? valid_b : valid_c;
    endfunction
    function automatic logic obs_drop(int i);
        return (i == 0) ? drop_a : (i == 1) ? drop_b : drop_c;
    endfunction
    function automatic logic [1:0] obs_st(int i);
        return (i == 0) ? st_a : (i == 1) ? st_b : st_c;
    endfunction

    function automatic bit is_one_hot(input logic [15:0] k);
        return (k != 0) && ($countones(k) == 1);
    endfunction

    // Derive the handshake edges at which each instance receives a commit for a
    // clean segment: key present from edge e0 for h samples, then zeros.
    task automatic schedule(input logic [15:0] key, input int unsigned e0, input int unsigned h);
        if (is_one_hot(key)) begin
            for (int i = 0; i < 3; i++) begin
                int unsigned p = press_c[i];
                if (h >= p + 1) begin
                    int unsigned q = e0 + p;
                    if (cor_c[i]) begin
                        evq.push_back('{i, e0 + h + RelCycles + 1, key});
                    end else begin
                        evq.push_back('{i, q + 1, key});
                        if (rep_c[i]) begin
                            for (int unsigned t = q + RptDelay; t <= e0 + h - 1; t += RptPeriod)
                                evq.push_back('{i, t + 1, key});
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_edge(input bit rdy);
        for (int i = 0; i < 3; i++) begin
            bit          hit = 1'b0;
            logic [15:0] k = '0;
            foreach (evq[j]) begin
                if (evq[j].inst == i && evq[j].edge_no == edge_cnt) begin
                    hit = 1'b1;
                    k   = evq[j].key;
                end
            end
            m_drop[i] = 1'b0;
            if (hit) begin
                if (!m_valid[i] || rdy) begin
                    m_data[i]  = k;
                    m_valid[i] = 1'b1;
                end else begin
                    m_drop[i] = 1'b1;
                end
            end else if (m_valid[i] && rdy) begin
                m_valid[i] = 1'b0;
            end
        end
        for (int j = evq.size() - 1; j >= 0; j--) begin
            if (evq[j].edge_no <= edge_cnt) evq.delete(j);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i), {31'd0, obs_valid(i)}, {31'd0, m_valid[i]});
            chk($sformatf("data%0d", i), {16'd0, obs_data(i)}, {16'd0, m_data[i]});
            chk($sformatf("drop%0d", i), {31'd0, obs_drop(i)}, {31'd0, m_drop[i]});
            if (chk_idle_st) chk($sformatf("idle_state%0d", i), {30'd0, obs_st(i)}, 32'd0);
        end
        if (chk_c_not_held) chk("c_never_held", {31'd0, st_c == 2'b10}, 32'd0);
    endtask

    task automatic step(input logic [15:0] k, input bit rdy);
        keys_in   = k;
        key_ready = rdy;
        @(posedge clk);
        edge_cnt++;
        model_edge(rdy);
        #1;
        if (valid_b) b_valid_cycles++;
        if (drop_a) a_drop_cycles++;
        check_all();
    endtask

    function automatic bit pick_ready(input int mode);
        return (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode);
    endfunction

    task automatic seg(input logic [15:0] key, input int unsigned h, input int unsigned g,
                       input int mode);
        schedule(key, edge_cnt + 1, h);
        for (int unsigned i = 0; i < h; i++) step(key, pick_ready(mode));
        for (int unsigned i = 0; i < g; i++) step(16'h0000, pick_ready(mode));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), {31'd0, obs_valid(i)}, 32'd0);
            chk($sformatf("rst_data%0d", i), {16'd0, obs_data(i)}, 32'd0);
            chk($sformatf("rst_state%0d", i), {30'd0, obs_st(i)}, 32'd0);
        end
        chk("rst_held_a", {31'd0, held_a}, 32'd0);
        chk("rst_drop_b", {31'd0, drop_b}, 32'd0);
        @(posedge clk);
        edge_cnt++;
        #1;
        rst = 1'b0;
        evq.delete();
        for (int i = 0; i < 3; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_drop[i]  = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_drop[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        edge_cnt = 0;
        check_all();
        chk("reset_state_b", {30'd0, st_b}, 32'd0);
        chk("reset_held_c", {31'd0, held_c}, 32'd0);
        rst = 1'b0;

        // Release-commit basic: 0x0020 for 10 cycles, then zeros.
        schedule(16'h0020, edge_cnt + 1, 10);
        for (int i = 0; i < 10; i++) step(16'h0020, 1'b1);
        chk("t1_held_state_a", {30'd0, st_a}, 32'd2);
        chk("t1_held_a", {31'd0, held_a}, 32'd1);
        step(16'h0000, 1'b1);
        chk("t1_relqual_state_a", {30'd0, st_a}, 32'd3);
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b1);
        chk("t1_idle_state_a", {30'd0, st_a}, 32'd0);
        chk("t1_not_yet_valid_a", {31'd0, valid_a}, 32'd0);
        step(16'h0000, 1'b1);
        chk("t1_valid_a", {31'd0, valid_a}, 32'd1);
        chk("t1_data_a", {16'd0, data_a}, 32'h0020);
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b1);

        // Bouncy press never qualifies with PRESS=8.
        chk_c_not_held = 1'b1;
        for (int i = 0; i < 10; i++) seg(16'h0004, 2, 2, 1);
        chk_c_not_held = 1'b0;

        // Multi-hot input is ignored.
        chk_idle_st = 1'b1;
        seg(16'h0011, 50, 5, 1);
        chk_idle_st = 1'b0;

        // Press commit with auto-repeat: 1 press + 1 delayed + 7 periodic.
        b_valid_cycles = 0;
        seg(16'h0100, 60, 10, 1);
        chk("t4_repeat_commits_b", b_valid_cycles, 32'd9);

        // Holding register full: second release commit is dropped.
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b1);
        a_drop_cycles = 0;
        seg(16'h0001, 6, 6, 0);
        seg(16'h0002, 6, 6, 0);
        chk("t5_data_a", {16'd0, data_a}, 32'h0001);
        chk("t5_drops_a", a_drop_cycles, 32'd1);
        step(16'h0000, 1'b1);
        chk("t5_cleared_a", {31'd0, valid_a}, 32'd0);
        chk("t5_keeps_data_a", {16'd0, data_a}, 32'h0001);

        // Reset during press qualification, key kept and re-qualified.
        for (int i = 0; i < 2; i++) step(16'h0008, 1'b1);
        pulse_reset();
        seg(16'h0008, 10, 8, 1);
        chk("t6_requal_data_a", {16'd0, data_a}, 32'h0008);
        // Reset during qualification, key released before re-qualifying.
        for (int i = 0; i < 2; i++) step(16'h0010, 1'b1);
        pulse_reset();
        seg(16'h0010, 2, 6, 1);
        chk("t6_no_commit_a", {31'd0, valid_a}, 32'd0);

        // Randomized clean segments with random ready.
        for (int n = 0; n < 30; n++) begin
            logic [15:0] key;
            int unsigned a = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) begin
                int unsigned b = (a + 1 + $urandom_range(0, 14)) % 16;
                key = (16'h1 << a) | (16'h1 << b);
            end else begin
                key = 16'h1 << a;
            end
            seg(key, $urandom_range(1, 45), $urandom_range(5, 10), 2);
        end
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
